// File: rtl/sp_ram_bist.sv
// March-style BIST / initialisation master for the single-port RAM wrapper.
// Runs write / read-compare / write-inverse / read-compare-inverse over every word.
module sp_ram_bist #(
    parameter int NUM_WORDS  = 8192,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   seed_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic [DATA_WIDTH-1:0]   err_data_o,
    output logic [15:0]             err_cnt_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_nextIdx;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [DATA_WIDTH-1:0] w_nextSeed;
    logic                  w_startAcc;
    logic                  w_lastIdx;

    logic                  w_nEn;
    logic                  w_nWe;
    logic [DATA_WIDTH-1:0] w_nWdata;
    logic [DATA_WIDTH-1:0] w_nextPat;
    logic [DATA_WIDTH-1:0] w_curPat;

    logic                  r_ramEn;
    logic                  r_ramWe;
    logic [ADDR_WIDTH-1:0] r_ramAddr;
    logic [DATA_WIDTH-1:0] r_ramWdata;
    logic [BE_W-1:0]       r_ramBe;

    logic                  r_cmpValid;
    logic [DATA_WIDTH-1:0] r_cmpExp;
    logic [ADDR_WIDTH-1:0] r_cmpAddr;
    logic                  w_mismatch;
    logic [15:0]           w_errCntNext;

    logic                  r_done;
    logic                  r_pass;
    logic [15:0]           r_errCnt;
    logic [ADDR_WIDTH-1:0] r_errAddr;
    logic [DATA_WIDTH-1:0] r_errData;

    assign w_lastIdx  = (r_idx == LAST_IDX);
    assign w_nextSeed = w_startAcc ? seed_i : r_seed;
    assign w_nextPat  = w_nextSeed ^ DATA_WIDTH'(w_nextIdx);
    assign w_curPat   = r_seed ^ DATA_WIDTH'(r_idx);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_seed  <= '0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
            r_seed  <= w_nextSeed;
        end
    end

    // The word index restarts at zero on every state change.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx + 1'b1;
        w_startAcc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_startAcc  = 1'b1;
                    w_nextState = S_WR0;
                end
            end
            S_WR0:   if (w_lastIdx) w_nextState = S_RD0;
            S_RD0:   if (w_lastIdx) w_nextState = S_WR1;
            S_WR1:   if (w_lastIdx) w_nextState = S_RD1;
            S_RD1:   if (w_lastIdx) w_nextState = S_FIN;
            S_FIN:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (w_nextState != r_state || r_state == S_IDLE) begin
            w_nextIdx = '0;
        end
    end

    // RAM command is decoded from the upcoming state so the port is fully registered.
    always_comb begin
        w_nEn    = 1'b0;
        w_nWe    = 1'b0;
        w_nWdata = '0;
        case (w_nextState)
            S_WR0: begin
                w_nEn    = 1'b1;
                w_nWe    = 1'b1;
                w_nWdata = w_nextPat;
            end
            S_WR1: begin
                w_nEn    = 1'b1;
                w_nWe    = 1'b1;
                w_nWdata = ~w_nextPat;
            end
            S_RD0, S_RD1: w_nEn = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ramEn    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            r_ramBe    <= '0;
        end else begin
            r_ramEn    <= w_nEn;
            r_ramWe    <= w_nWe;
            r_ramAddr  <= w_nEn ? ADDR_WIDTH'({w_nextIdx, 2'b00}) : '0;
            r_ramWdata <= w_nWdata;
            r_ramBe    <= w_nEn ? {BE_W{1'b1}} : '0;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_cmpValid <= 1'b0;
            r_cmpExp   <= '0;
            r_cmpAddr  <= '0;
        end else begin
            r_cmpValid <= (r_state == S_RD0) || (r_state == S_RD1);
            r_cmpExp   <= (r_state == S_RD1) ? ~w_curPat : w_curPat;
            r_cmpAddr  <= r_ramAddr;
        end
    end

    assign w_mismatch = r_cmpValid && (ram_rdata_i != r_cmpExp);

    always_comb begin
        w_errCntNext = r_errCnt;
        if (w_mismatch && r_errCnt != 16'hFFFF) begin
            w_errCntNext = r_errCnt + 16'd1;
        end
    end

    // Pass uses the post-compare count so the final RD1 word, checked in FIN, is included.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_errCnt  <= '0;
            r_errAddr <= '0;
            r_errData <= '0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (w_startAcc) begin
                r_pass    <= 1'b0;
                r_errCnt  <= '0;
                r_errAddr <= '0;
                r_errData <= '0;
            end else begin
                if (w_mismatch) begin
                    r_errCnt <= w_errCntNext;
                    if (r_errCnt == 16'd0) begin
                        r_errAddr <= r_cmpAddr;
                        r_errData <= ram_rdata_i;
                    end
                end
                if (r_state == S_FIN) begin
                    r_pass <= (w_errCntNext == 16'd0);
                end
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign err_cnt_o   = r_errCnt;
    assign err_addr_o  = r_errAddr;
    assign err_data_o  = r_errData;
    assign ram_en_o    = r_ramEn;
    assign ram_we_o    = r_ramWe;
    assign ram_addr_o  = r_ramAddr;
    assign ram_wdata_o = r_ramWdata;
    assign ram_be_o    = r_ramBe;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Bench for sp_ram_bist: 4-word RAM model with injectable faults and a pass-level
// reference model of the march result, timing and write traffic.
module tb_sp_ram_bist;

    localparam int N       = 4;
    localparam int AW      = 15;
    localparam int DW      = 32;
    localparam int RUN_CYC = 4 * N + 2;
    localparam int LIMIT   = RUN_CYC + 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [DW-1:0] seed_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [AW-1:0] err_addr_o;
    logic [DW-1:0] err_data_o;
    logic [15:0]   err_cnt_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [DW-1:0] ram_rdata_i;

    int checks   = 0;
    int failures = 0;

    int   faultMode;
    int   faultWord;
    int   faultBit;
    logic faultVal;

    logic [DW-1:0] mem [0:N-1];
    logic [AW-1:0] wrAddrQ [$];
    logic [DW-1:0] wrDataQ [$];

    sp_ram_bist #(
        .NUM_WORDS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .seed_i     (seed_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .err_addr_o (err_addr_o),
        .err_data_o (err_data_o),
        .err_cnt_o  (err_cnt_o),
        .ram_en_o   (ram_en_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_we_o   (ram_we_o),
        .ram_be_o   (ram_be_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Mode 1: one bit of one word stuck at faultVal; mode 2: read data forced to zero.
    function automatic logic [DW-1:0] faultRead(input int w, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (faultMode == 1 && w == faultWord) r[faultBit] = faultVal;
        else if (faultMode == 2) r = '0;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        w = int'(ram_addr_o[AW-1:2]);
        if (ram_en_o && w < N) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[w][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
                wrAddrQ.push_back(ram_addr_o);
                wrDataQ.push_back(ram_wdata_o);
            end else begin
                ram_rdata_i <= faultRead(w, mem[w]);
            end
        end
    end

    task automatic computeExpected(input logic [DW-1:0] seed, output logic [15:0] cnt,
                                   output logic [DW-1:0] addr, output logic [DW-1:0] data);
        logic [DW-1:0] m [N];
        logic [DW-1:0] exp;
        logic [DW-1:0] rd;
        cnt  = 0;
        addr = 0;
        data = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) m[i] = (p == 0) ? (seed ^ DW'(i)) : ~(seed ^ DW'(i));
            for (int i = 0; i < N; i++) begin
                exp = m[i];
                rd  = faultRead(i, m[i]);
                if (rd != exp) begin
                    if (cnt == 0) begin
                        addr = DW'(i * 4);
                        data = rd;
                    end
                    cnt = cnt + 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"},     busy_o,      0);
        checkOutput({pfx, "_done"},     done_o,      0);
        checkOutput({pfx, "_pass"},     pass_o,      0);
        checkOutput({pfx, "_err_cnt"},  err_cnt_o,   0);
        checkOutput({pfx, "_err_addr"}, err_addr_o,  0);
        checkOutput({pfx, "_err_data"}, err_data_o,  0);
        checkOutput({pfx, "_ram_en"},   ram_en_o,    0);
        checkOutput({pfx, "_ram_we"},   ram_we_o,    0);
        checkOutput({pfx, "_ram_be"},   ram_be_o,    0);
        checkOutput({pfx, "_ram_addr"}, ram_addr_o,  0);
        checkOutput({pfx, "_ram_wdata"}, ram_wdata_o, 0);
    endtask

    // One full run; start pulses at cycles pokeA/pokeB must be ignored. With chain set,
    // the next start is driven in the done cycle and the next call passes started=1.
    task automatic applyStimulus(input logic [DW-1:0] seed, input bit started,
                                 input int pokeA, input int pokeB,
                                 input bit chain, input logic [DW-1:0] chainSeed);
        logic [15:0]   eCnt;
        logic [DW-1:0] eAddr;
        logic [DW-1:0] eData;
        int  k;
        int  phase;
        int  idx;
        bit  expEn;
        bit  expWe;
        bit  gotDone;
        computeExpected(seed, eCnt, eAddr, eData);
        wrAddrQ.delete();
        wrDataQ.delete();
        if (!started) begin
            seed_i  = seed;
            start_i = 1'b1;
        end
        @(negedge clk);
        start_i = 1'b0;
        k       = 1;
        gotDone = 1'b0;
        checkOutput("clr_err_cnt", err_cnt_o, 0);
        checkOutput("clr_err_addr", err_addr_o, 0);
        checkOutput("clr_err_data", err_data_o, 0);
        checkOutput("clr_pass", pass_o, 0);
        while (1) begin
            if (done_o === 1'b1) begin
                gotDone = 1'b1;
                break;
            end
            if (k <= 4 * N + 1) begin
                phase = (k - 1) / N;
                idx   = (k - 1) % N;
                expEn = (k <= 4 * N);
                expWe = expEn && (phase % 2 == 0);
                checkOutput("run_busy", busy_o, 1);
                checkOutput("run_en", ram_en_o, expEn);
                checkOutput("run_we", ram_we_o, expWe);
                checkOutput("run_be", ram_be_o, expEn ? 4'hF : 4'h0);
                if (expEn) checkOutput("run_addr", ram_addr_o, idx * 4);
                if (expWe) checkOutput("run_wdata", ram_wdata_o,
                                       (phase == 0) ? (seed ^ DW'(idx)) : ~(seed ^ DW'(idx)));
            end
            if (k >= LIMIT) break;
            start_i = (k == pokeA) || (k == pokeB);
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        checkOutput("done_cycle", gotDone ? k : 0, RUN_CYC);
        checkOutput("res_busy", busy_o, 0);
        checkOutput("res_pass", pass_o, (eCnt == 0));
        checkOutput("res_err_cnt", err_cnt_o, eCnt);
        checkOutput("res_err_addr", err_addr_o, eAddr);
        checkOutput("res_err_data", err_data_o, eData);
        checkOutput("wr_count", wrAddrQ.size(), 2 * N);
        for (int j = 0; j < wrAddrQ.size() && j < 2 * N; j++) begin
            checkOutput("wr_addr", wrAddrQ[j], (j % N) * 4);
            checkOutput("wr_data", wrDataQ[j],
                        (j < N) ? (seed ^ DW'(j % N)) : ~(seed ^ DW'(j % N)));
        end
        if (chain) begin
            seed_i  = chainSeed;
            start_i = 1'b1;
        end else begin
            @(negedge clk);
            checkOutput("done_single_pulse", done_o, 0);
            checkOutput("no_restart_busy", busy_o, 0);
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        seed_i    = '0;
        faultMode = 0;
        faultWord = 0;
        faultBit  = 0;
        faultVal  = 1'b0;
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        $display("[TB] clean run");
        applyStimulus(32'hA5A50000, 1'b0, 0, 0, 1'b0, '0);
        checkOutput("clean_pass", pass_o, 1);
        checkOutput("clean_cnt", err_cnt_o, 0);

        $display("[TB] stuck-at-1 bit 0 of word 2");
        faultMode = 1; faultWord = 2; faultBit = 0; faultVal = 1'b1;
        applyStimulus(32'hA5A50000, 1'b0, 0, 0, 1'b0, '0);
        checkOutput("stuck_cnt", err_cnt_o, 1);
        checkOutput("stuck_addr", err_addr_o, 32'h8);
        checkOutput("stuck_data", err_data_o, 32'hA5A50003);
        checkOutput("stuck_pass", pass_o, 0);

        $display("[TB] read data forced to zero");
        faultMode = 2;
        applyStimulus(32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, '0);
        checkOutput("zero_cnt", err_cnt_o, 7);
        checkOutput("zero_addr", err_addr_o, 0);
        checkOutput("zero_data", err_data_o, 0);
        checkOutput("zero_pass", pass_o, 0);

        $display("[TB] start pulses in RD0 and FIN ignored");
        faultMode = 0;
        applyStimulus($urandom, 1'b0, N + 2, 4 * N + 1, 1'b0, '0);

        $display("[TB] reset in the middle of WR1");
        seed_i  = $urandom;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2 * N + 1) @(negedge clk);
        checkOutput("pre_rst_we", ram_we_o, 1);
        rst_i = 1'b1;
        #1;
        checkAllZero("midrun_rst");
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < RUN_CYC + 4; c++) begin
            @(negedge clk);
            checkOutput("post_rst_no_done", done_o, 0);
        end
        applyStimulus($urandom, 1'b0, 0, 0, 1'b0, '0);
        checkOutput("post_rst_pass", pass_o, 1);

        $display("[TB] back-to-back runs");
        faultMode = 2;
        applyStimulus($urandom, 1'b0, 0, 0, 1'b1, $urandom);
        faultMode = 0;
        applyStimulus(seed_i, 1'b1, 0, 0, 1'b0, '0);

        $display("[TB] randomized fault runs");
        for (int r = 0; r < 6; r++) begin
            faultMode = $urandom_range(0, 2);
            faultWord = $urandom_range(0, N - 1);
            faultBit  = $urandom_range(0, DW - 1);
            faultVal  = 1'($urandom_range(0, 1));
            applyStimulus($urandom, 1'b0, 0, 0, 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
